// File: rtl/perif_temporizador_if.sv
// Port-side bus between the CPU and the interval-timer peripheral:
// command byte and end-of-ISR pulse from the CPU, readback byte and
// interrupt request from the device.
interface perif_temporizador_if;
  logic [7:0] cmd;
  logic       finInterrup;
  logic [7:0] dato;
  logic       intPort;

  modport master (output cmd, output finInterrup, input dato, input intPort);
  modport slave  (input cmd, input finInterrup, output dato, output intPort);
endinterface

// File: rtl/perif_temporizador.sv
// perif_temporizador: programmable interval timer on the CPU port side.
// Commands arrive as a toggle-qualified byte; expiry raises a level
// interrupt that the CPU clears with finInterrup or an acknowledge command.
// Optional feature macro: PERIF_TEMPORIZADOR_OVERRUN_EN (overrun flag).
module perif_temporizador #(
  parameter int unsigned PRESC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  perif_temporizador_if.slave  bus
);

  typedef enum logic {PARADO = 1'b0, CONTANDO = 1'b1} state_e;

  localparam logic [7:0] PRESC_MAX = 8'(PRESC - 1);

  state_e     state_q, state_d;
  logic       tog_q, tog_d;
  logic [7:0] period_q, period_d;
  logic [7:0] count_q, count_d;
  logic [7:0] presc_q, presc_d;
  logic       autoreload_q, autoreload_d;
  logic       sel_q, sel_d;
  logic       pending_q, pending_d;
  logic       ovr_s;

  logic       cmd_new_s, ctrl_s, ack_s, clr_s, tick_s, expire_s;
  logic [1:0] op_s;

`ifdef PERIF_TEMPORIZADOR_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Overrun flag: set when an expiry finds pending still set and not being cleared.
  always_comb begin
    overrun_d = overrun_q;
    if (ack_s) begin
      overrun_d = 1'b0;
    end else if (expire_s && pending_q && !clr_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Overrun register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign ovr_s = overrun_q;
`else
  assign ovr_s = 1'b0;
`endif

  // Next-state logic: counting, expiry, interrupt clear, then command decode
  // last so a control command overrides whatever the counter would do.
  always_comb begin
    state_d      = state_q;
    tog_d        = tog_q;
    period_d     = period_q;
    count_d      = count_q;
    presc_d      = presc_q;
    autoreload_d = autoreload_q;
    sel_d        = sel_q;
    pending_d    = pending_q;

    cmd_new_s = (bus.cmd[7] != tog_q);
    op_s      = bus.cmd[6:5];
    ctrl_s    = cmd_new_s && (op_s == 2'b11);
    ack_s     = cmd_new_s && (op_s == 2'b00);
    clr_s     = bus.finInterrup || ack_s;
    tick_s    = (state_q == CONTANDO) && (presc_q == PRESC_MAX);
    expire_s  = tick_s && (count_q == 8'd1) && !ctrl_s;

    // Prescaler runs only while counting and wraps on the tick.
    if (state_q == CONTANDO) begin
      if (tick_s) begin
        presc_d = 8'd0;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end else begin
      presc_d = presc_q;
    end

    // Count: reload or stop on expiry, otherwise decrement with 8-bit wrap.
    if (expire_s) begin
      if (autoreload_q) begin
        count_d = period_q;
        state_d = CONTANDO;
      end else begin
        count_d = 8'd0;
        state_d = PARADO;
      end
    end else if (tick_s) begin
      count_d = count_q - 8'd1;
    end else begin
      count_d = count_q;
    end

    // Expiry takes precedence over a simultaneous clear.
    if (expire_s) begin
      pending_d = 1'b1;
    end else if (clr_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (cmd_new_s) begin
      tog_d = bus.cmd[7];
      sel_d = bus.cmd[4];
      case (op_s)
        2'b01:   period_d[3:0] = bus.cmd[3:0];
        2'b10:   period_d[7:4] = bus.cmd[3:0];
        2'b11: begin
          autoreload_d = bus.cmd[1];
          if (bus.cmd[0]) begin
            count_d = period_q;
            presc_d = 8'd0;
            state_d = CONTANDO;
          end else begin
            count_d = count_q;
            presc_d = presc_q;
            state_d = PARADO;
          end
        end
        default: ;  // acknowledge: handled through clr_s / ack_s
      endcase
    end else begin
      tog_d = tog_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PARADO;
      tog_q        <= 1'b0;
      period_q     <= 8'd0;
      count_q      <= 8'd0;
      presc_q      <= 8'd0;
      autoreload_q <= 1'b0;
      sel_q        <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tog_q        <= tog_d;
      period_q     <= period_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      autoreload_q <= autoreload_d;
      sel_q        <= sel_d;
      pending_q    <= pending_d;
    end
  end

  // Readback mux: count or status byte, straight from registers.
  always_comb begin
    if (sel_q) begin
      bus.dato = {pending_q, ovr_s, (state_q == CONTANDO), autoreload_q, 4'b0000};
    end else begin
      bus.dato = count_q;
    end
  end

  assign bus.intPort = pending_q;

endmodule

// File: tb/tb_perif_temporizador.sv
// Directed bench for perif_temporizador: one instance with PRESC=4 and one
// with PRESC=1, sharing clock and reset.
module tb_perif_temporizador;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n;

`ifdef PERIF_TEMPORIZADOR_OVERRUN_EN
  localparam logic [7:0] STAT_OVR = 8'hF0;
`else
  localparam logic [7:0] STAT_OVR = 8'hB0;
`endif

  perif_temporizador_if bus4 ();
  perif_temporizador_if bus1 ();

  perif_temporizador #(.PRESC(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  perif_temporizador #(.PRESC(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One clock edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus4.cmd = 8'h00; bus4.finInterrup = 1'b0;
    bus1.cmd = 8'h00; bus1.finInterrup = 1'b0;
    step(); step();
    check_val("rst_dato4", {8'h00, bus4.dato}, 16'h0000);
    check_val("rst_int4", {15'd0, bus4.intPort}, 16'h0000);
    check_val("rst_dato1", {8'h00, bus1.dato}, 16'h0000);
    reset = 1'b0;
    step();

    // Period 5, one-shot: expiry 20 cycles after the enable edge.
    bus4.cmd = 8'hA5; step();
    bus4.cmd = 8'h40; step();
    bus4.cmd = 8'hE1; step();
    check_val("en_count", {8'h00, bus4.dato}, 16'd5);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i == 4) check_val("count_after_tick", {8'h00, bus4.dato}, 16'd4);
      if (bus4.intPort) begin n = i; break; end
    end
    check_val("oneshot_latency", 16'(n), 16'd20);
    check_val("oneshot_count0", {8'h00, bus4.dato}, 16'd0);
    bus4.cmd = 8'h35; step();
    check_val("oneshot_status", {8'h00, bus4.dato}, 16'h0080);

    // finInterrup clears the request.
    bus4.finInterrup = 1'b1; step();
    bus4.finInterrup = 1'b0;
    check_val("fin_clear", {15'd0, bus4.intPort}, 16'd0);

    // Held command executes once: one expiry, then stays stopped at 0.
    bus4.cmd = 8'hE1;
    for (int i = 0; i < 50; i++) step();
    check_val("hold_int", {15'd0, bus4.intPort}, 16'd1);
    check_val("hold_count", {8'h00, bus4.dato}, 16'd0);

    // Autoreload period 3, no ack: second expiry flags overrun.
    bus4.cmd = 8'h00; step();
    check_val("ack_clear", {15'd0, bus4.intPort}, 16'd0);
    bus4.cmd = 8'hA3; step();
    bus4.cmd = 8'h40; step();
    bus4.cmd = 8'hE3; step();
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus4.intPort) begin n = i; break; end
    end
    check_val("auto_first", 16'(n), 16'd12);
    bus4.cmd = 8'h33; step();                      // edge 13
    check_val("auto_status1", {8'h00, bus4.dato}, 16'h00B0);
    for (int i = 0; i < 10; i++) step();           // edge 23
    check_val("auto_status23", {8'h00, bus4.dato}, 16'h00B0);
    step();                                        // edge 24: second expiry
    check_val("auto_status_ovr", {8'h00, bus4.dato}, {8'h00, STAT_OVR});

    // Ack, then finInterrup coinciding with the third expiry (edge 36).
    bus4.cmd = 8'h90; step();                      // edge 25
    check_val("ack_status", {8'h00, bus4.dato}, 16'h0030);
    for (int i = 0; i < 10; i++) step();           // edge 35
    check_val("pre_expiry_int", {15'd0, bus4.intPort}, 16'd0);
    bus4.finInterrup = 1'b1; step();               // edge 36
    bus4.finInterrup = 1'b0;
    check_val("fin_vs_expiry_int", {15'd0, bus4.intPort}, 16'd1);
    check_val("fin_vs_expiry_stat", {8'h00, bus4.dato}, 16'h00B0);

    // Asynchronous reset mid-count with the request raised.
    reset = 1'b1;
    #1;
    check_val("async_rst_int", {15'd0, bus4.intPort}, 16'd0);
    check_val("async_rst_dato", {8'h00, bus4.dato}, 16'h0000);
    step();
    reset = 1'b0;
    step();

    // PRESC=1, period 0: wrap 0 -> 255 and expiry after 256 cycles.
    bus1.cmd = 8'hE1; step();
    check_val("p0_en_count", {8'h00, bus1.dato}, 16'd0);
    step();
    check_val("p0_wrap", {8'h00, bus1.dato}, 16'd255);
    n = 0;
    for (int i = 2; i <= 400; i++) begin
      step();
      if (bus1.intPort) begin n = i; break; end
    end
    check_val("p0_latency", 16'(n), 16'd256);
    check_val("p4_idle_int", {15'd0, bus4.intPort}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
